// File: rtl/stoken_pkg.sv
// Shared definitions for the self-timed token pipeline receive/transmit edges.
// Token layout is node | gen | operand, MSB first.
package stoken_pkg;

  localparam int NODE_W = 16;
  localparam int GEN_W  = 12;
  localparam int OPR_W  = 32;
  localparam int DATA_W = NODE_W + GEN_W + OPR_W;

  typedef struct packed {
    logic [NODE_W-1:0] node;
    logic [GEN_W-1:0]  gen;
    logic [OPR_W-1:0]  opr;
  } token_t;

  typedef enum logic [1:0] {
    DRAIN = 2'd0,
    IDLE  = 2'd1,
    ACK   = 2'd2
  } rx_state_e;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for a single asynchronous control bit.
// The flops are cleared by rst so the synchronised level is known after reset.
module sync_ff #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/stoken_rx_sync.sv
// Clocked receiver for the self-timed token pipeline: synchronises the 4-phase
// send line, captures bundled data into a small FIFO and offers it via valid/ready.
module stoken_rx_sync #(
  parameter int DATA_W      = stoken_pkg::DATA_W,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       send_i,
  input  logic [DATA_W-1:0]          data_i,
  output logic                       ack_o,
  output logic                       tok_valid_o,
  output logic [DATA_W-1:0]          tok_data_o,
  input  logic                       tok_ready_i,
  output logic [$clog2(DEPTH):0]     fifo_cnt_o,
  output logic [15:0]                rx_cnt_o
);

  import stoken_pkg::*;

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int DWEL_W = $clog2(SYNC_STAGES + 1);

  logic              send_s;
  rx_state_e         state_q, state_d;
  logic [DWEL_W-1:0] dwell_q, dwell_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       rx_cnt_q, rx_cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              push;
  logic              pop;
  logic              full;

  sync_ff #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_send_sync (
    .clk (clk),
    .rst (rst),
    .d_i (send_i),
    .q_o (send_s)
  );

  assign full = (cnt_q == CNT_W'(DEPTH));
  assign pop  = (cnt_q != '0) && tok_ready_i;

  // DRAIN dwells until the cleared synchroniser reflects the live send line,
  // otherwise a request held high across reset would read as low and be re-captured.
  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    unique case (state_q)
      DRAIN: begin
        if (dwell_q != DWEL_W'(SYNC_STAGES)) begin
          dwell_d = dwell_q + 1'b1;
        end else if (!send_s) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (send_s && !full) begin
          state_d = ACK;
        end
      end
      ACK: begin
        if (!send_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = DRAIN;
    endcase
  end

  always_comb begin
    ack_o = (state_q == ACK);
    push  = (state_q == IDLE) && send_s && !full;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
    rx_cnt_d = rx_cnt_q + 16'(push);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= DRAIN;
      dwell_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      rx_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      dwell_q  <= dwell_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      rx_cnt_q <= rx_cnt_d;
    end
  end

  // Payload storage is not reset; emptiness is tracked by cnt_q alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign tok_valid_o = (cnt_q != '0);
  assign tok_data_o  = tok_valid_o ? mem_q[rd_ptr_q] : '0;
  assign fifo_cnt_o  = cnt_q;
  assign rx_cnt_o    = rx_cnt_q;

endmodule

// File: tb/tb_stoken_rx_sync.sv
// Bench for stoken_rx_sync: directed scenarios plus random handshakes, checked
// every cycle against a queue-based model of the handshake and FIFO rules.
module tb_stoken_rx_sync;
  import stoken_pkg::*;

  localparam int DW    = 60;
  localparam int DEPTH = 4;
  localparam int SS    = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          send_i = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic          ack_o;
  logic          tok_valid_o;
  logic [DW-1:0] tok_data_o;
  logic          tok_ready_i = 1'b0;
  logic [2:0]    fifo_cnt_o;
  logic [15:0]   rx_cnt_o;

  always #5 clk = ~clk;

  stoken_rx_sync #(
    .DATA_W      (DW),
    .DEPTH       (DEPTH),
    .SYNC_STAGES (SS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .send_i      (send_i),
    .data_i      (data_i),
    .ack_o       (ack_o),
    .tok_valid_o (tok_valid_o),
    .tok_data_o  (tok_data_o),
    .tok_ready_i (tok_ready_i),
    .fifo_cnt_o  (fifo_cnt_o),
    .rx_cnt_o    (rx_cnt_o)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: send_s is send_i as sampled SS edges ago; a token is
  // taken at most once per synchronised high phase, only when there is room,
  // and never until the line has been seen low after reset.
  logic [DW-1:0] mq[$];
  logic [15:0]   m_rx = '0;
  logic          m_cap = 1'b0;
  logic          m_armed = 1'b0;
  int            m_since = 0;
  logic          hist[SS];
  logic          m_live = 1'b0;

  always @(posedge clk) begin : model
    logic s;
    logic was_full;
    if (rst) begin
      mq.delete();
      m_rx    = '0;
      m_cap   = 1'b0;
      m_armed = 1'b0;
      m_since = 0;
      for (int i = 0; i < SS; i++) hist[i] = 1'b0;
      m_live  = 1'b1;
    end else if (m_live) begin
      s        = hist[SS-1];
      was_full = (mq.size() >= DEPTH);
      if (mq.size() > 0 && tok_ready_i) void'(mq.pop_front());
      if (!m_armed) begin
        if (m_since >= SS && !s) m_armed = 1'b1;
      end else if (m_cap) begin
        if (!s) m_cap = 1'b0;
      end else if (s && !was_full) begin
        mq.push_back(data_i);
        m_cap = 1'b1;
        m_rx  = m_rx + 16'd1;
      end
      if (m_since < SS) m_since++;
      for (int i = SS - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = send_i;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("ack_o", 64'(ack_o), 64'(m_cap));
      chk("tok_valid_o", 64'(tok_valid_o), 64'(mq.size() != 0));
      chk("tok_data_o", 64'(tok_data_o), (mq.size() != 0) ? 64'(mq[0]) : 64'd0);
      chk("fifo_cnt_o", 64'(fifo_cnt_o), 64'(mq.size()));
      chk("rx_cnt_o", 64'(rx_cnt_o), 64'(m_rx));
    end
  end

  // 0: ready low, 1: ready high, 2: random, 3: driven by the scenario
  int rmode = 0;
  always @(negedge clk) begin
    case (rmode)
      0: tok_ready_i = 1'b0;
      1: tok_ready_i = 1'b1;
      2: tok_ready_i = 1'($urandom_range(0, 1));
      default: ;
    endcase
  end

  function automatic logic [DW-1:0] rand_tok();
    token_t tk;
    tk.node = 16'($urandom);
    tk.gen  = 12'($urandom);
    tk.opr  = $urandom;
    return tk;
  endfunction

  task automatic wait_ack(input logic lvl, input int budget, input string name);
    int t = 0;
    while (ack_o !== lvl && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk(name, 64'(ack_o), 64'(lvl));
  endtask

  task automatic hs(input logic [DW-1:0] d, input int gap);
    @(negedge clk);
    data_i = d;
    send_i = 1'b1;
    wait_ack(1'b1, 200, "hs_ack_rise");
    send_i = 1'b0;
    wait_ack(1'b0, 50, "hs_ack_fall");
    repeat (gap) @(negedge clk);
    data_i = rand_tok();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [DW-1:0] d5;
    do_reset();
    chk("reset_ack", 64'(ack_o), 64'd0);
    chk("reset_valid", 64'(tok_valid_o), 64'd0);
    chk("reset_data", 64'(tok_data_o), 64'd0);
    chk("reset_cnt", 64'(fifo_cnt_o), 64'd0);
    chk("reset_rx", 64'(rx_cnt_o), 64'd0);

    // Single token: capture on the third edge after send_i rises
    rmode  = 0;
    data_i = 60'h0123_456_89AB_CDEF;
    send_i = 1'b1;
    repeat (2) @(negedge clk);
    chk("single_ack_edge2", 64'(ack_o), 64'd0);
    @(negedge clk);
    chk("single_ack_edge3", 64'(ack_o), 64'd1);
    chk("single_valid", 64'(tok_valid_o), 64'd1);
    chk("single_data", 64'(tok_data_o), 64'h0123_4568_9ABC_DEF);
    chk("single_rx", 64'(rx_cnt_o), 64'd1);
    repeat (17) @(negedge clk);
    send_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("single_fall_edge2", 64'(ack_o), 64'd1);
    @(negedge clk);
    chk("single_fall_edge3", 64'(ack_o), 64'd0);
    rmode = 1;
    repeat (3) @(negedge clk);

    // Back-pressure: four fit, the fifth waits for a pop
    rmode = 0;
    for (int i = 0; i < 4; i++) hs(rand_tok(), 1);
    chk("bp_cnt_full", 64'(fifo_cnt_o), 64'd4);
    d5 = rand_tok();
    @(negedge clk);
    data_i = d5;
    send_i = 1'b1;
    repeat (10) @(negedge clk);
    chk("bp_held_ack", 64'(ack_o), 64'd0);
    chk("bp_held_cnt", 64'(fifo_cnt_o), 64'd4);
    rmode = 3;
    tok_ready_i = 1'b1;
    @(negedge clk);
    tok_ready_i = 1'b0;
    chk("bp_pop_cnt", 64'(fifo_cnt_o), 64'd3);
    chk("bp_pop_ack", 64'(ack_o), 64'd0);
    @(negedge clk);
    chk("bp_late_ack", 64'(ack_o), 64'd1);
    chk("bp_late_cnt", 64'(fifo_cnt_o), 64'd4);
    send_i = 1'b0;
    wait_ack(1'b0, 20, "bp_ack_fall");
    rmode = 1;
    repeat (8) @(negedge clk);
    chk("bp_drained", 64'(fifo_cnt_o), 64'd0);

    // Push and pop in the capture cycle
    rmode = 0;
    hs(rand_tok(), 0);
    hs(rand_tok(), 0);
    chk("pp_cnt2", 64'(fifo_cnt_o), 64'd2);
    rmode = 3;
    tok_ready_i = 1'b0;
    @(negedge clk);
    data_i = rand_tok();
    send_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tok_ready_i = 1'b1;
    @(negedge clk);
    tok_ready_i = 1'b0;
    chk("pp_ack", 64'(ack_o), 64'd1);
    chk("pp_cnt_same", 64'(fifo_cnt_o), 64'd2);
    send_i = 1'b0;
    wait_ack(1'b0, 20, "pp_ack_fall");
    rmode = 2;
    for (int i = 0; i < 9; i++) hs(rand_tok(), $urandom_range(0, 3));
    rmode = 1;
    repeat (8) @(negedge clk);

    // Reset while acknowledging with send_i still high
    rmode = 0;
    @(negedge clk);
    data_i = rand_tok();
    send_i = 1'b1;
    wait_ack(1'b1, 10, "rst_pre_ack");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ack", 64'(ack_o), 64'd0);
    chk("rst_cnt", 64'(fifo_cnt_o), 64'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rst_no_recapture", 64'(ack_o), 64'd0);
    end
    chk("rst_rx_zero", 64'(rx_cnt_o), 64'd0);
    send_i = 1'b0;
    repeat (5) @(negedge clk);
    send_i = 1'b1;
    wait_ack(1'b1, 20, "rst_recapture");
    chk("rst_rx_one", 64'(rx_cnt_o), 64'd1);
    send_i = 1'b0;
    wait_ack(1'b0, 20, "rst_ack_fall");

    // rx counter wrap
    rmode = 1;
    repeat (3) @(negedge clk);
    #2;
    force dut.rx_cnt_q = 16'hFFFE;
    m_rx = 16'hFFFE;
    @(negedge clk);
    #2;
    release dut.rx_cnt_q;
    hs(rand_tok(), 1);
    chk("wrap_ffff", 64'(rx_cnt_o), 64'hFFFF);
    hs(rand_tok(), 1);
    chk("wrap_0000", 64'(rx_cnt_o), 64'h0000);

    // Sub-period pulse between rising edges is never sampled
    @(negedge clk);
    #1 send_i = 1'b1;
    #2 send_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("glitch_ack", 64'(ack_o), 64'd0);
    end
    chk("glitch_rx", 64'(rx_cnt_o), 64'h0000);

    // Random traffic
    rmode = 2;
    for (int i = 0; i < 40; i++) hs(rand_tok(), $urandom_range(0, 4));
    rmode = 1;
    repeat (10) @(negedge clk);
    chk("final_empty", 64'(fifo_cnt_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
